// File: rtl/trade_scheduler.sv
// rtl/trade_scheduler.sv - arbitrates auto/manual orders onto one execution port with a position limit and cool-down
// Optional auto requester and round-robin arbitration are built when TRADE_SCHED_AUTO_EN is defined.
module trade_scheduler #(
    parameter int PRICE_W    = 8,
    parameter int POS_W      = 8,
    parameter int MAX_POS    = 10,
    parameter int BUY_LIMIT  = 60,
    parameter int SELL_LIMIT = 75,
    parameter int COOLDOWN   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [PRICE_W-1:0] buy_price,
    input  logic [PRICE_W-1:0] sell_price,
    input  logic               user_buy_req,
    input  logic               user_sell_req,
    input  logic               exec_ready,
    output logic               exec_valid,
    output logic               exec_side,
    output logic [PRICE_W-1:0] exec_price,
    output logic               exec_src,
    output logic [POS_W-1:0]   position,
    output logic [15:0]        trade_cnt,
    output logic               reject,
    output logic [7:0]         drop_cnt,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_COOL
    } state_t;

    localparam logic [POS_W-1:0] POS_HI    = POS_W'(MAX_POS);
    localparam logic [POS_W-1:0] POS_LO    = POS_W'(-MAX_POS);
    localparam logic [15:0]      COOL_INIT = (COOLDOWN > 0) ? 16'(COOLDOWN - 1) : 16'd0;

    state_t             state;
    state_t             state_d;
    logic [15:0]        cool_cnt;

    logic               man_vld;
    logic               man_side;
    logic [PRICE_W-1:0] man_price;

    logic               any_pend;
    logic               grant_man;
    logic               g_side;
    logic [PRICE_W-1:0] g_price;
    logic               grant;
    logic               limit_hit;
    logic               accept;
    logic               man_granted;
    logic               man_both;
    logic               man_one;
    logic               man_drop;

`ifdef TRADE_SCHED_AUTO_EN
    localparam logic [PRICE_W-1:0] BUY_LIM  = PRICE_W'(BUY_LIMIT);
    localparam logic [PRICE_W-1:0] SELL_LIM = PRICE_W'(SELL_LIMIT);

    logic               auto_vld;
    logic               auto_side;
    logic [PRICE_W-1:0] auto_price;
    logic               rr;

    // rr = 1 gives the manual requester priority when both are pending
    always_comb begin
        any_pend  = auto_vld | man_vld;
        grant_man = man_vld;
        if (auto_vld && man_vld) begin
            grant_man = rr;
        end
        g_side  = grant_man ? man_side  : auto_side;
        g_price = grant_man ? man_price : auto_price;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            auto_vld   <= 1'b0;
            auto_side  <= 1'b0;
            auto_price <= '0;
            rr         <= 1'b0;
        end else begin
            if (grant && !grant_man) begin
                auto_vld <= 1'b0;
            end
            if (tick) begin
                if (sell_price <= BUY_LIM) begin
                    auto_vld   <= 1'b1;
                    auto_side  <= 1'b1;
                    auto_price <= sell_price;
                end else if (buy_price >= SELL_LIM) begin
                    auto_vld   <= 1'b1;
                    auto_side  <= 1'b0;
                    auto_price <= buy_price;
                end else begin
                    auto_vld <= 1'b0;
                end
            end
            if (grant) begin
                rr <= ~grant_man;
            end
        end
    end
`else
    logic unused_auto;
    assign unused_auto = ^{tick, PRICE_W'(BUY_LIMIT), PRICE_W'(SELL_LIMIT)};

    always_comb begin
        any_pend  = man_vld;
        grant_man = 1'b1;
        g_side    = man_side;
        g_price   = man_price;
    end
`endif

    assign grant       = (state == S_IDLE) && any_pend;
    assign limit_hit   = g_side ? (position == POS_HI) : (position == POS_LO);
    assign accept      = (state == S_ISSUE) && exec_ready;
    assign man_granted = grant && grant_man;
    assign man_both    = user_buy_req && user_sell_req;
    assign man_one     = user_buy_req ^ user_sell_req;
    assign man_drop    = man_both || (man_one && man_vld && !man_granted);
    assign busy        = (state != S_IDLE);

    // A pulse on the edge that grants the manual entry refills it
    always_ff @(posedge clk) begin
        if (reset) begin
            man_vld   <= 1'b0;
            man_side  <= 1'b0;
            man_price <= '0;
            drop_cnt  <= 8'd0;
        end else begin
            if (man_granted) begin
                man_vld <= 1'b0;
            end
            if (man_one && !man_drop) begin
                man_vld   <= 1'b1;
                man_side  <= user_buy_req;
                man_price <= user_buy_req ? sell_price : buy_price;
            end
            if (man_drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (grant && !limit_hit) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (exec_ready) begin
                    state_d = (COOLDOWN == 0) ? S_IDLE : S_COOL;
                end
            end
            S_COOL: begin
                if (cool_cnt == 16'd0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cool_cnt   <= 16'd0;
            exec_valid <= 1'b0;
            exec_side  <= 1'b0;
            exec_price <= '0;
            exec_src   <= 1'b0;
            position   <= '0;
            trade_cnt  <= 16'd0;
            reject     <= 1'b0;
        end else begin
            state  <= state_d;
            reject <= grant && limit_hit;
            if (grant && !limit_hit) begin
                exec_valid <= 1'b1;
                exec_side  <= g_side;
                exec_price <= g_price;
                exec_src   <= grant_man;
            end
            if (accept) begin
                exec_valid <= 1'b0;
                trade_cnt  <= trade_cnt + 16'd1;
                position   <= exec_side ? position + POS_W'(1) : position - POS_W'(1);
                cool_cnt   <= COOL_INIT;
            end else if (state == S_COOL && cool_cnt != 16'd0) begin
                cool_cnt <= cool_cnt - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_trade_scheduler.sv
// tb/tb_trade_scheduler.sv - directed self-checking bench for trade_scheduler
module tb_trade_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] buy_price = 8'd0;
    logic [7:0] sell_price = 8'd0;
    logic       user_buy_req = 1'b0;
    logic       user_sell_req = 1'b0;
    logic       exec_ready = 1'b0;
    logic       exec_valid;
    logic       exec_side;
    logic [7:0] exec_price;
    logic       exec_src;
    logic [7:0] position;
    logic [15:0] trade_cnt;
    logic       reject;
    logic [7:0] drop_cnt;
    logic       busy;

    int checks = 0;
    int passed = 0;

    trade_scheduler dut (
        .clk(clk), .reset(reset), .tick(tick),
        .buy_price(buy_price), .sell_price(sell_price),
        .user_buy_req(user_buy_req), .user_sell_req(user_sell_req),
        .exec_ready(exec_ready), .exec_valid(exec_valid), .exec_side(exec_side),
        .exec_price(exec_price), .exec_src(exec_src), .position(position),
        .trade_cnt(trade_cnt), .reject(reject), .drop_cnt(drop_cnt), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Issues one manual order with exec_ready high and waits until the scheduler is idle again
    task automatic manual_trade(input logic is_buy);
        int n;
        user_buy_req  = is_buy;
        user_sell_req = ~is_buy;
        step();
        user_buy_req  = 1'b0;
        user_sell_req = 1'b0;
        n = 0;
        while (!exec_valid && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (!exec_valid) $display("FAIL trade_issue_timeout: exec_valid got %b want 1", exec_valid);
        else passed++;
        n = 0;
        while ((busy || exec_valid) && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (exec_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", exec_valid); else passed++;
        checks++; if ({exec_side, exec_src, exec_price} !== 10'd0) $display("FAIL rst_exec: got %h want 0", {exec_side, exec_src, exec_price}); else passed++;
        checks++; if (position !== 8'd0) $display("FAIL rst_position: got %0d want 0", position); else passed++;
        checks++; if (trade_cnt !== 16'd0) $display("FAIL rst_trade_cnt: got %0d want 0", trade_cnt); else passed++;
        checks++; if ({reject, busy} !== 2'b00) $display("FAIL rst_reject_busy: got %b want 00", {reject, busy}); else passed++;
        checks++; if (drop_cnt !== 8'd0) $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); else passed++;
        exec_ready = 1'b1;
        repeat (3) step();
        exec_ready = 1'b0;
        checks++; if ({exec_valid, position, trade_cnt} !== 25'd0) $display("FAIL idle_ready_ignored: got %h want 0", {exec_valid, position, trade_cnt}); else passed++;
    endtask

    task automatic test_manual_buy();
        int busy_n;
        do_reset();
        exec_ready = 1'b1;
        sell_price = 8'd70;
        buy_price  = 8'd50;
        user_buy_req = 1'b1;
        step();
        user_buy_req = 1'b0;
        checks++; if (exec_valid !== 1'b0) $display("FAIL mb_latency1: exec_valid got %b want 0", exec_valid); else passed++;
        step();
        checks++; if (exec_valid !== 1'b1) $display("FAIL mb_valid: got %b want 1", exec_valid); else passed++;
        checks++; if ({exec_side, exec_src} !== 2'b11) $display("FAIL mb_side_src: got %b want 11", {exec_side, exec_src}); else passed++;
        checks++; if (exec_price !== 8'd70) $display("FAIL mb_price: got %0d want 70", exec_price); else passed++;
        busy_n = busy ? 1 : 0;
        step();
        checks++; if (exec_valid !== 1'b0) $display("FAIL mb_accept_valid: got %b want 0", exec_valid); else passed++;
        checks++; if (position !== 8'd1) $display("FAIL mb_position: got %0d want 1", position); else passed++;
        checks++; if (trade_cnt !== 16'd1) $display("FAIL mb_trade_cnt: got %0d want 1", trade_cnt); else passed++;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            busy_n++;
            step();
        end
        checks++; if (busy_n !== 5) $display("FAIL mb_busy_cycles: got %0d want 5", busy_n); else passed++;
    endtask

    task automatic test_hold();
        int n;
        do_reset();
        exec_ready = 1'b0;
        sell_price = 8'd70;
        buy_price  = 8'd50;
        user_sell_req = 1'b1;
        step();
        user_sell_req = 1'b0;
        step();
        checks++; if ({exec_valid, exec_side, exec_src, exec_price} !== {3'b101, 8'd50}) $display("FAIL hold_issue: got %h want %h", {exec_valid, exec_side, exec_src, exec_price}, {3'b101, 8'd50}); else passed++;
        buy_price  = 8'd40;
        sell_price = 8'd65;
        for (int i = 0; i < 10; i++) begin
            user_buy_req  = (i == 2);
            user_sell_req = (i == 5);
            step();
            user_buy_req  = 1'b0;
            user_sell_req = 1'b0;
            checks++;
            if ({exec_valid, exec_side, exec_price} !== {2'b10, 8'd50}) $display("FAIL hold_stable_%0d: got %h want %h", i, {exec_valid, exec_side, exec_price}, {2'b10, 8'd50});
            else passed++;
        end
        checks++; if (drop_cnt !== 8'd1) $display("FAIL hold_drop_cnt: got %0d want 1", drop_cnt); else passed++;
        exec_ready = 1'b1;
        step();
        checks++; if (exec_valid !== 1'b0) $display("FAIL hold_accept_valid: got %b want 0", exec_valid); else passed++;
        checks++; if (position !== 8'hFF) $display("FAIL hold_position: got %h want ff", position); else passed++;
        n = 0;
        while (!exec_valid && n < 20) begin
            step();
            n++;
        end
        checks++; if (n !== 5) $display("FAIL hold_spacing: got %0d want 5", n); else passed++;
        checks++; if ({exec_side, exec_src, exec_price} !== {2'b11, 8'd65}) $display("FAIL hold_pending_buy: got %h want %h", {exec_side, exec_src, exec_price}, {2'b11, 8'd65}); else passed++;
        step();
        checks++; if ({position, trade_cnt} !== {8'd0, 16'd2}) $display("FAIL hold_final: got %h want %h", {position, trade_cnt}, {8'd0, 16'd2}); else passed++;
    endtask

    task automatic test_limit();
        do_reset();
        exec_ready = 1'b1;
        sell_price = 8'd70;
        buy_price  = 8'd50;
        for (int k = 0; k < 10; k++) manual_trade(1'b1);
        checks++; if (position !== 8'd10) $display("FAIL lim_position10: got %0d want 10", position); else passed++;
        checks++; if (trade_cnt !== 16'd10) $display("FAIL lim_trade_cnt10: got %0d want 10", trade_cnt); else passed++;
        user_buy_req = 1'b1;
        step();
        user_buy_req = 1'b0;
        step();
        checks++; if ({reject, exec_valid, busy} !== 3'b100) $display("FAIL lim_reject: got %b want 100", {reject, exec_valid, busy}); else passed++;
        step();
        checks++; if ({reject, exec_valid} !== 2'b00) $display("FAIL lim_reject_pulse: got %b want 00", {reject, exec_valid}); else passed++;
        checks++; if (position !== 8'd10) $display("FAIL lim_position_hold: got %0d want 10", position); else passed++;
        manual_trade(1'b0);
        checks++; if ({position, exec_side} !== {8'd9, 1'b0}) $display("FAIL lim_sell: got %h want %h", {position, exec_side}, {8'd9, 1'b0}); else passed++;
        checks++; if (trade_cnt !== 16'd11) $display("FAIL lim_trade_cnt11: got %0d want 11", trade_cnt); else passed++;
    endtask

    task automatic test_simultaneous_and_reset();
        do_reset();
        exec_ready = 1'b1;
        user_buy_req  = 1'b1;
        user_sell_req = 1'b1;
        step();
        user_buy_req  = 1'b0;
        user_sell_req = 1'b0;
        checks++; if (drop_cnt !== 8'd1) $display("FAIL both_drop_cnt: got %0d want 1", drop_cnt); else passed++;
        step();
        step();
        checks++; if ({exec_valid, busy} !== 2'b00) $display("FAIL both_no_issue: got %b want 00", {exec_valid, busy}); else passed++;
        exec_ready = 1'b0;
        sell_price = 8'd70;
        user_buy_req = 1'b1;
        step();
        user_buy_req = 1'b0;
        step();
        checks++; if (exec_valid !== 1'b1) $display("FAIL rmid_pre_valid: got %b want 1", exec_valid); else passed++;
        reset = 1'b1;
        exec_ready = 1'b1;
        step();
        reset = 1'b0;
        exec_ready = 1'b0;
        checks++; if ({exec_valid, busy, reject} !== 3'b000) $display("FAIL rmid_valid_busy: got %b want 000", {exec_valid, busy, reject}); else passed++;
        checks++; if ({position, trade_cnt} !== 24'd0) $display("FAIL rmid_pos_cnt: got %h want 0", {position, trade_cnt}); else passed++;
        checks++; if ({drop_cnt, exec_side, exec_src, exec_price} !== 18'd0) $display("FAIL rmid_others: got %h want 0", {drop_cnt, exec_side, exec_src, exec_price}); else passed++;
    endtask

`ifdef TRADE_SCHED_AUTO_EN
    task automatic test_auto_rr();
        int n;
        do_reset();
        exec_ready = 1'b1;
        sell_price = 8'd58;
        buy_price  = 8'd50;
        tick = 1'b1;
        user_sell_req = 1'b1;
        step();
        tick = 1'b0;
        user_sell_req = 1'b0;
        step();
        checks++; if ({exec_valid, exec_side, exec_src, exec_price} !== {3'b110, 8'd58}) $display("FAIL auto_first: got %h want %h", {exec_valid, exec_side, exec_src, exec_price}, {3'b110, 8'd58}); else passed++;
        step();
        n = 0;
        while (!exec_valid && n < 20) begin
            step();
            n++;
        end
        checks++; if (n !== 5) $display("FAIL auto_spacing: got %0d want 5", n); else passed++;
        checks++; if ({exec_side, exec_src, exec_price} !== {2'b01, 8'd50}) $display("FAIL auto_second: got %h want %h", {exec_side, exec_src, exec_price}, {2'b01, 8'd50}); else passed++;
        step();
        checks++; if ({position, trade_cnt} !== {8'd0, 16'd2}) $display("FAIL auto_final: got %h want %h", {position, trade_cnt}, {8'd0, 16'd2}); else passed++;
    endtask
`else
    task automatic test_no_auto();
        logic seen;
        do_reset();
        exec_ready = 1'b1;
        sell_price = 8'd55;
        buy_price  = 8'd50;
        tick = 1'b1;
        step();
        tick = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen = seen | exec_valid | busy;
            step();
        end
        checks++; if (seen !== 1'b0) $display("FAIL noauto_tick_ignored: got %b want 0", seen); else passed++;
        user_sell_req = 1'b1;
        step();
        user_sell_req = 1'b0;
        step();
        checks++; if ({exec_valid, exec_side, exec_src, exec_price} !== {3'b101, 8'd50}) $display("FAIL noauto_manual_sell: got %h want %h", {exec_valid, exec_side, exec_src, exec_price}, {3'b101, 8'd50}); else passed++;
        step();
        checks++; if (position !== 8'hFF) $display("FAIL noauto_position: got %h want ff", position); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_manual_buy();
        test_hold();
        test_limit();
        test_simultaneous_and_reset();
`ifdef TRADE_SCHED_AUTO_EN
        test_auto_rr();
`else
        test_no_auto();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
